// File: rtl/data_mem_lane.sv
// data_mem_lane: byte-addressed MEM-stage data memory, 32-bit big-endian words
// held as four byte-lane arrays. Valid/ready request, registered 1-cycle response,
// hardware zero-clear of the array after reset (INIT_CLEAR=1).
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// respond with resp_err=1 instead of having their low address bits ignored.
module data_mem_lane #(
  parameter int ADDR_W     = 12,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int WI    = ADDR_W - 2;
  localparam int DEPTH = 2 ** WI;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [WI-1:0] cnt;

  logic          accept;
  logic          store_en;
  logic [WI-1:0] word_idx;
  logic [1:0]    off;
  logic          err;
  logic [3:0]    lane_en;
  logic [31:0]   wword;
  logic [31:0]   rd_word;
  logic [31:0]   ld_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign accept   = req_valid & req_ready;
  assign store_en = accept & req_we & ~err;
  assign word_idx = req_addr[ADDR_W-1:2];

  // Decode effective lane offset, error, lane enables, lane-replicated store data
  // and the extended load value.
  always_comb begin
    off     = req_addr[1:0];
    err     = (req_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      err = 1'b1;
`else
    if (req_size == 2'b01)
      off = {req_addr[1], 1'b0};
    else if (req_size == 2'b10)
      off = 2'b00;
`endif
    lane_en = 4'b0000;
    wword   = req_wdata;
    case (req_size)
      2'b00: begin
        lane_en[off] = 1'b1;
        wword        = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en[off]         = 1'b1;
        lane_en[off | 2'b01] = 1'b1;
        wword                = {2{req_wdata[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    // lane 0 sits in bits 31:24, so lane n starts at bit 8*(3-n)
    ld_byte = rd_word[{~off, 3'b000} +: 8];
    ld_half = off[1] ? rd_word[15:0] : rd_word[31:16];
    case (req_size)
      2'b00:   ld_val = {{24{req_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{req_signed & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0]    mem [DEPTH];
      logic          we_l;
      logic [WI-1:0] idx_l;
      logic [7:0]    d_l;

      assign we_l  = ~rst & ((state == INIT) | (store_en & lane_en[gi]));
      assign idx_l = (state == INIT) ? cnt : word_idx;
      assign d_l   = (state == INIT) ? 8'h00 : wword[8*(3-gi) +: 8];

      // Lane write port: clear sequence or selected store lane
      always_ff @(posedge clk) begin
        if (we_l)
          mem[idx_l] <= d_l;
      end

      assign rd_word[8*(3-gi) +: 8] = mem[word_idx];
    end
  endgenerate

  // Control FSM: clear sweep, then permanent RUN with registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT_CLEAR ? INIT : RUN;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt        <= cnt + 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          if (&cnt) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end
        end
        RUN: begin
          req_ready  <= 1'b1;
          resp_valid <= accept;
          resp_err   <= accept & err;
          resp_rdata <= (accept & ~req_we & ~err) ? ld_val : 32'h0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_lane.md
Name: data_mem_lane

Overview:
- Parametrised successor to the pipeline's byte-addressed data memory.
- Stores 32-bit big-endian words as four byte lanes and supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Uses a valid/ready request channel and a registered 1-cycle response.
- After reset, a hardware clear sequence zeroes the whole array.
- Sits in the MEM stage between the execute-result latch and the write-back latch.

Parameters:
- ADDR_W, default 12: byte-address width. Depth is 2**(ADDR_W-2) words.
- INIT_CLEAR, default 1:
  - 1: the array is zeroed by the clear sequence after reset.
  - 0: no clear; the array keeps its contents across reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  access request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-justified for byte and halfword
- resp_valid  output  1  one-cycle pulse completing an accepted request
- resp_rdata  output  32  load result, extended
- resp_err  output  1  access was rejected (see below)

Behaviour:
- Reset (asynchronous): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, clear counter=0.
  - State after reset: INIT if INIT_CLEAR=1, otherwise RUN.
  - The array itself is not reset.
- FSM states:
  - INIT: writes zero to word[cnt] on all four lanes each cycle; cnt increments each cycle. req_ready=0.
  - INIT exits to RUN at the edge where cnt = DEPTH-1. The clear takes exactly DEPTH cycles.
  - RUN: req_ready=1 permanently. There is no return to INIT except through rst.
  - rst asserted mid-INIT restarts the clear at word 0.
- Handshake:
  - A request is accepted at a rising edge where req_valid & req_ready.
  - One request can be accepted per cycle; back-to-back requests are legal.
  - The response has no backpressure.
- Response timing: resp_valid=1 in the cycle after acceptance, for exactly one cycle. Both loads and stores respond.
  - Store response: resp_rdata=0.
  - Load response: resp_rdata is registered.
- Byte lanes (big-endian): addr[1:0]=0 selects bits 31:24, 1 selects 23:16, 2 selects 15:8, 3 selects 7:0.
- Stores:
  - Byte: writes req_wdata[7:0] to the lane selected by addr[1:0].
  - Halfword: writes req_wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word: writes all four lanes.
  - Unselected lanes are unchanged.
  - The write is committed at the accepting edge.
- Loads:
  - The selected byte or halfword is placed in resp_rdata[7:0] or [15:0].
  - The upper bits are filled with the MSB of the loaded value if req_signed=1, else with 0.
  - req_signed is ignored for word loads.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- req_size=11: resp_err=1, no write, resp_rdata=0.
- Misalignment (halfword with addr[0]=1, word with addr[1:0]!=0): handled per the optional feature below.
- Word index is req_addr[ADDR_W-1:2]. Out-of-range addresses do not exist.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access responds with resp_err=1 and resp_rdata=0.
  - The array is not modified.
  - Timing is unchanged.
- Undefined:
  - Misaligned low address bits are ignored: a halfword access uses addr[0]=0; a word access uses addr[1:0]=0.
  - resp_err is asserted only for req_size=11.

Test Plan:
- Reset then INIT with ADDR_W=6 -> req_ready stays 0 for 16 cycles after rst falls, then goes to 1. A word load from 0x3C returns 0x00000000 with resp_err=0.
- Word store 0x11223344 to 0x10, then byte store 0xAA to 0x12, then word load 0x10 -> response 0x1122AA44 one cycle after acceptance, resp_valid high for 1 cycle.
- After 0x80FF7F01 is stored at 0x20:
  - Byte load 0x20 signed -> 0xFFFFFF80.
  - Byte load 0x20 unsigned -> 0x00000080.
  - Halfword load 0x22 signed -> 0x00007F01.
- Back-to-back: word store 0xDEADBEEF to 0x04 followed in the next cycle by a word load from 0x04 -> load response 0xDEADBEEF. Two consecutive resp_valid pulses.
- Misaligned word store 0xCAFEBABE to 0x05:
  - With DMEM_MISALIGN_TRAP_EN: resp_err=1, and a word load from 0x04 still returns the old value.
  - Without the macro: word 0x04 becomes 0xCAFEBABE and resp_err=0.
- rst pulsed in mid-INIT cycle 5 -> all outputs return to reset values immediately. The clear restarts and req_ready rises DEPTH cycles after the second rst deassertion. req_size=11 in RUN -> resp_err=1.
